// File: rtl/fetch_ctrl.sv
// Fetch PC sequencer with a direct-mapped branch target buffer.
// Redirects from execute override stalls; BTB trains on resolved branches.
module fetch_ctrl #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int              BTB_ENTRIES  = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall_F,
    input  logic            x_redirect,
    input  logic [XLEN-1:0] x_target,
    input  logic            x_upd,
    input  logic [XLEN-1:0] x_pc,
    input  logic            x_taken,
    input  logic [XLEN-1:0] x_dest,
    output logic [XLEN-1:0] pc_F,
    output logic [1:0]      pc_F_sel,
    output logic            pred_taken_F,
    output logic            flush_D
);

    localparam int IDX = $clog2(BTB_ENTRIES);
    localparam int TW  = XLEN - IDX - 2;

    localparam logic [1:0] SEL_SEQ   = 2'd0;
    localparam logic [1:0] SEL_PRED  = 2'd1;
    localparam logic [1:0] SEL_REDIR = 2'd2;
    localparam logic [1:0] SEL_RST   = 2'd3;

    logic [BTB_ENTRIES-1:0] r_valid;
    logic [TW-1:0]          r_tag [BTB_ENTRIES];
    logic [XLEN-1:0]        r_tgt [BTB_ENTRIES];

    logic [XLEN-1:0] r_pc;
    logic [1:0]      r_sel;
    logic            r_flush;

    logic [IDX-1:0]  w_idx;
    logic [TW-1:0]   w_tag;
    logic            w_hit;
    logic [IDX-1:0]  w_uidx;
    logic [TW-1:0]   w_utag;
    logic            w_umatch;

    assign w_idx    = r_pc[IDX+1:2];
    assign w_tag    = r_pc[XLEN-1:IDX+2];
    assign w_hit    = r_valid[w_idx] && (r_tag[w_idx] == w_tag);

    assign w_uidx   = x_pc[IDX+1:2];
    assign w_utag   = x_pc[XLEN-1:IDX+2];
    assign w_umatch = r_valid[w_uidx] && (r_tag[w_uidx] == w_utag);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc    <= RESET_VECTOR;
            r_sel   <= SEL_RST;
            r_flush <= 1'b0;
            r_valid <= '0;
        end else begin
            r_flush <= x_redirect;
            if (x_redirect) begin
                r_pc  <= x_target;
                r_sel <= SEL_REDIR;
            end else if (!stall_F) begin
                if (w_hit) begin
                    r_pc  <= r_tgt[w_idx];
                    r_sel <= SEL_PRED;
                end else begin
                    r_pc  <= r_pc + XLEN'(4);
                    r_sel <= SEL_SEQ;
                end
            end
            // Not-taken only clears an entry that really belongs to x_pc
            if (x_upd) begin
                if (x_taken) begin
                    r_valid[w_uidx] <= 1'b1;
                end else if (w_umatch) begin
                    r_valid[w_uidx] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (x_upd && x_taken) begin
            r_tag[w_uidx] <= w_utag;
            r_tgt[w_uidx] <= x_dest;
        end
    end

    assign pc_F         = r_pc;
    assign pc_F_sel     = r_sel;
    assign flush_D      = r_flush;
    assign pred_taken_F = w_hit;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: a reference model queues expected
// fetch state per cycle, compared after each rising edge.
module tb_fetch_ctrl;

    logic        clk;
    logic        rst;
    logic        stall_F;
    logic        x_redirect;
    logic [31:0] x_target;
    logic        x_upd;
    logic [31:0] x_pc;
    logic        x_taken;
    logic [31:0] x_dest;
    logic [31:0] pc_F;
    logic [1:0]  pc_F_sel;
    logic        pred_taken_F;
    logic        flush_D;

    fetch_ctrl #(
        .XLEN(32),
        .RESET_VECTOR(32'h0),
        .BTB_ENTRIES(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .stall_F(stall_F),
        .x_redirect(x_redirect),
        .x_target(x_target),
        .x_upd(x_upd),
        .x_pc(x_pc),
        .x_taken(x_taken),
        .x_dest(x_dest),
        .pc_F(pc_F),
        .pc_F_sel(pc_F_sel),
        .pred_taken_F(pred_taken_F),
        .flush_D(flush_D)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [1:0]  sel;
        logic        fl;
        logic        pr;
    } exp_t;

    exp_t q[$];

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0]  m_v;
    logic [26:0] m_tag [8];
    logic [31:0] m_tgt [8];
    logic [31:0] m_pc;
    logic [1:0]  m_sel;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic m_hit(input logic [31:0] pc);
        return m_v[pc[4:2]] && (m_tag[pc[4:2]] == pc[31:5]);
    endfunction

    task automatic idle_inputs();
        stall_F    = 1'b0;
        x_redirect = 1'b0;
        x_target   = '0;
        x_upd      = 1'b0;
        x_pc       = '0;
        x_taken    = 1'b0;
        x_dest     = '0;
    endtask

    task automatic step(input logic red, input logic [31:0] tgt,
                        input logic stl, input logic upd,
                        input logic [31:0] upc, input logic tk,
                        input logic [31:0] dst);
        exp_t e;
        exp_t g;
        logic h;
        stall_F    = stl;
        x_redirect = red;
        x_target   = tgt;
        x_upd      = upd;
        x_pc       = upc;
        x_taken    = tk;
        x_dest     = dst;
        h = m_hit(m_pc);
        if (red) begin
            m_pc  = tgt;
            m_sel = 2'd2;
        end else if (!stl) begin
            if (h) begin
                m_pc  = m_tgt[m_pc[4:2]];
                m_sel = 2'd1;
            end else begin
                m_pc  = m_pc + 32'd4;
                m_sel = 2'd0;
            end
        end
        if (upd) begin
            if (tk) begin
                m_v[upc[4:2]]   = 1'b1;
                m_tag[upc[4:2]] = upc[31:5];
                m_tgt[upc[4:2]] = dst;
            end else if (m_hit(upc)) begin
                m_v[upc[4:2]] = 1'b0;
            end
        end
        e.pc  = m_pc;
        e.sel = m_sel;
        e.fl  = red;
        e.pr  = m_hit(m_pc);
        q.push_back(e);
        @(posedge clk);
        #1;
        idle_inputs();
        g = q.pop_front();
        chk("pc_F", pc_F, g.pc);
        chk("pc_F_sel", {30'd0, pc_F_sel}, {30'd0, g.sel});
        chk("flush_D", {31'd0, flush_D}, {31'd0, g.fl});
        chk("pred_taken_F", {31'd0, pred_taken_F}, {31'd0, g.pr});
    endtask

    task automatic go();
        step(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, '0);
    endtask

    task automatic redir(input logic [31:0] t);
        step(1'b1, t, 1'b0, 1'b0, '0, 1'b0, '0);
    endtask

    task automatic model_reset();
        m_v   = '0;
        m_pc  = 32'h0;
        m_sel = 2'd3;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_pc"}, pc_F, 32'h0);
        chk({tag, "_sel"}, {30'd0, pc_F_sel}, 32'd3);
        chk({tag, "_flush"}, {31'd0, flush_D}, 32'd0);
        chk({tag, "_pred"}, {31'd0, pred_taken_F}, 32'd0);
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk_reset_state("rst");
        rst = 1'b0;

        // Free-running after reset
        go(); go(); go();
        chk("seq_C", pc_F, 32'h0000000C);
        go();
        chk("seq_10", pc_F, 32'h00000010);

        // Redirect wins over stall
        step(1'b1, 32'h200, 1'b1, 1'b0, '0, 1'b0, '0);
        chk("redir_pc", pc_F, 32'h00000200);
        chk("redir_flush", {31'd0, flush_D}, 32'd1);
        go();
        chk("after_redir", pc_F, 32'h00000204);
        chk("flush_clear", {31'd0, flush_D}, 32'd0);

        // Train taken branch at 0x40
        step(1'b0, '0, 1'b0, 1'b1, 32'h40, 1'b1, 32'h100);
        redir(32'h3C);
        go();
        chk("hit_40", {31'd0, pred_taken_F}, 32'd1);
        go();
        chk("pred_pc", pc_F, 32'h00000100);
        chk("pred_sel", {30'd0, pc_F_sel}, 32'd1);

        // Aliasing not-taken must leave 0x40 entry intact
        step(1'b0, '0, 1'b0, 1'b1, 32'h60, 1'b0, '0);
        redir(32'h40);
        chk("alias_keep", {31'd0, pred_taken_F}, 32'd1);
        go();

        // Not-taken on 0x40 invalidates it
        step(1'b0, '0, 1'b0, 1'b1, 32'h40, 1'b0, '0);
        redir(32'h40);
        chk("inval_miss", {31'd0, pred_taken_F}, 32'd0);
        go();
        chk("inval_seq", pc_F, 32'h00000044);

        // Same-cycle write/lookup uses old contents
        redir(32'h40);
        step(1'b0, '0, 1'b0, 1'b1, 32'h40, 1'b1, 32'h300);
        chk("prewrite", pc_F, 32'h00000044);
        redir(32'h40);
        chk("postwrite", {31'd0, pred_taken_F}, 32'd1);
        go();

        // Wrap and back-to-back redirects
        redir(32'hFFFFFFFC);
        go();
        chk("wrap_pc", pc_F, 32'h00000000);
        chk("wrap_sel", {30'd0, pc_F_sel}, 32'd0);
        redir(32'h80);
        redir(32'h90);
        chk("b2b_flush", {31'd0, flush_D}, 32'd1);
        step(1'b0, '0, 1'b1, 1'b0, '0, 1'b0, '0);
        step(1'b0, '0, 1'b1, 1'b0, '0, 1'b0, '0);
        chk("stall_hold", pc_F, 32'h00000090);
        chk("stall_sel", {30'd0, pc_F_sel}, 32'd2);

        // Randomised traffic over a small aliasing PC set
        for (int i = 0; i < 300; i++) begin
            logic [31:0] rp;
            logic [31:0] rt;
            rp = {24'd0, 3'($urandom_range(0, 7)), 5'd0} |
                 {27'd0, 3'($urandom_range(0, 7)), 2'd0};
            rt = {22'd0, 8'($urandom), 2'b00};
            step(($urandom_range(0, 9) == 0), rt,
                 ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 2) == 0), rp,
                 1'($urandom), {23'd0, 7'($urandom), 2'b00});
        end

        // Async reset mid-stall with BTB populated and a pending redirect
        step(1'b0, '0, 1'b0, 1'b1, 32'h20, 1'b1, 32'h400);
        step(1'b0, '0, 1'b1, 1'b1, 32'h24, 1'b1, 32'h500);
        @(negedge clk);
        stall_F    = 1'b1;
        x_redirect = 1'b1;
        x_target   = 32'h700;
        x_upd      = 1'b1;
        x_pc       = 32'h28;
        x_taken    = 1'b1;
        x_dest     = 32'h600;
        #2;
        rst = 1'b1;
        #1;
        chk_reset_state("async_rst");
        @(posedge clk);
        #1;
        idle_inputs();
        model_reset();
        chk_reset_state("rst_hold");
        rst = 1'b0;
        go();
        chk("rst_first", pc_F, 32'h00000004);
        redir(32'h20);
        chk("rst_miss20", {31'd0, pred_taken_F}, 32'd0);
        redir(32'h24);
        chk("rst_miss24", {31'd0, pred_taken_F}, 32'd0);
        redir(32'h28);
        chk("rst_miss28", {31'd0, pred_taken_F}, 32'd0);
        go();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter XLEN, default 32, PC and target width in bits.
REQ-002 Parameter RESET_VECTOR, default 0, PC value loaded on reset.
REQ-003 Parameter BTB_ENTRIES, default 8, branch-target-buffer depth, power of two, at least 2.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 stall_F  input  1  hold the fetch PC this cycle.
REQ-007 x_redirect  input  1  execute-stage command to redirect fetch (mispredict or unpredicted jump).
REQ-008 x_target  input  XLEN  correct next PC when x_redirect=1.
REQ-009 x_upd  input  1  resolved control-transfer instruction in execute; update BTB.
REQ-010 x_pc  input  XLEN  PC of the resolved instruction.
REQ-011 x_taken  input  1  resolved instruction was taken.
REQ-012 x_dest  input  XLEN  resolved taken target, written into BTB.
REQ-013 pc_F  output  XLEN  current fetch PC, registered.
REQ-014 pc_F_sel  output  2  registered source of pc_F: 0 sequential, 1 predicted, 2 redirect, 3 reset.
REQ-015 pred_taken_F  output  1  BTB hit for pc_F (combinational from pc_F and BTB state).
REQ-016 flush_D  output  1  registered; kill the instruction currently in Decode.

Function
REQ-017 BTB SHALL be direct-mapped: index = pc[IDX+1:2], IDX=log2(BTB_ENTRIES); tag = pc[XLEN-1:IDX+2]; each entry holds valid, tag, target.
REQ-018 Hit SHALL mean valid and stored tag equals tag of pc_F; pred_taken_F = hit.
REQ-019 Next PC priority SHALL be: x_redirect -> x_target (sel 2); else stall_F -> hold pc_F and pc_F_sel unchanged; else hit -> stored target (sel 1); else pc_F+4 (sel 0).
REQ-020 x_redirect SHALL override stall_F in the same cycle.
REQ-021 pc_F+4 SHALL wrap modulo 2^XLEN (0xFFFFFFFC -> 0x00000000 for XLEN=32).
REQ-022 flush_D SHALL be 1 exactly in the cycle after a cycle with x_redirect=1, else 0; back-to-back redirects give consecutive flush_D pulses.
REQ-023 On x_upd=1 and x_taken=1 the entry at index(x_pc) SHALL be written valid=1, tag(x_pc), x_dest, overwriting any prior entry.
REQ-024 On x_upd=1 and x_taken=0 the entry at index(x_pc) SHALL be invalidated only if valid and tag matches tag(x_pc); otherwise unchanged.
REQ-025 BTB writes SHALL take effect at the clock edge; a same-cycle lookup of the same index uses pre-write contents.
REQ-026 BTB updates SHALL occur regardless of stall_F and x_redirect.
REQ-027 x_pc, x_dest, x_target low two bits SHALL be ignored for indexing; stored values are used unmodified.
REQ-028 Latency: a redirect asserted in cycle N SHALL appear on pc_F in cycle N+1.

Reset
REQ-029 While rst=1, asynchronously: pc_F=RESET_VECTOR, pc_F_sel=3, flush_D=0, all BTB valid bits=0; pred_taken_F therefore 0.
REQ-030 Reset asserted mid-operation SHALL discard any pending redirect or update in that cycle; first edge after rst falls SHALL load RESET_VECTOR+4 (sel 0) unless stall_F or x_redirect.
REQ-031 BTB tag and target storage need not be reset.

Verification
REQ-032 Reset then 3 free cycles, RESET_VECTOR=0 -> pc_F 0,4,8,0xC; pc_F_sel 3,0,0,0; flush_D 0.
REQ-033 At pc_F=0x10 assert x_redirect, x_target=0x200, stall_F=1 -> next pc_F=0x200, pc_F_sel=2, flush_D=1 one cycle, then 0x204.
REQ-034 x_upd=1, x_taken=1, x_pc=0x40, x_dest=0x100; later fetch reaches 0x40 -> pred_taken_F=1, next pc_F=0x100 sel 1; then x_upd, x_taken=0, x_pc=0x40 -> 0x40 next fetched gives pred_taken_F=0, next 0x44.
REQ-035 Aliasing (BTB_ENTRIES=8): entry for 0x40 valid, x_upd not-taken for 0x60 (same index, different tag) -> 0x40 entry remains valid.
REQ-036 Wrap: redirect to 0xFFFFFFFC -> next pc_F 0x00000000, sel 0.
REQ-037 Assert rst asynchronously mid-stall with BTB populated -> pc_F=RESET_VECTOR immediately, all lookups miss after release.
